// File: rtl/mem_wb_if.sv
// mem_wb_if: handshake, memory-return and register-file write bundle for mem_writeback_stage
interface mem_wb_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        RegDst;
  logic        MemToReg;
  logic        RegWrite;
  logic [31:0] alu_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif
  modport master (
    output in_valid, opcode, rt, rd, RegDst, MemToReg, RegWrite, alu_result, mem_rvalid, mem_rdata,
`ifdef WB_FWD_EN
    input fwd_valid, fwd_addr, fwd_data,
`endif
    input in_ready, wb_en, wb_addr, wb_data, busy
  );
  modport slave (
    input in_valid, opcode, rt, rd, RegDst, MemToReg, RegWrite, alu_result, mem_rvalid, mem_rdata,
`ifdef WB_FWD_EN
    output fwd_valid, fwd_addr, fwd_data,
`endif
    output in_ready, wb_en, wb_addr, wb_data, busy
  );
endinterface

// File: rtl/mem_writeback_stage.sv
// mem_writeback_stage: writeback FSM with load extension; define WB_FWD_EN for early bypass outputs
module mem_writeback_stage (
  input logic clk,
  input logic rst_n,
  mem_wb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, WB} state_t;
  state_t      r_state;
  logic [5:0]  r_op;
  logic [4:0]  r_dst;
  logic        r_wb_en;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data;
  logic        w_acc;
  logic        w_cap;
  logic [4:0]  w_dst;
  logic [31:0] w_ext;
  function automatic logic [31:0] ext(input logic [5:0] op, input logic [31:0] d);
    return op == 6'h20 ? {{24{d[7]}}, d[7:0]} :
           op == 6'h21 ? {{16{d[15]}}, d[15:0]} :
           op == 6'h24 ? {24'h0, d[7:0]} :
           op == 6'h25 ? {16'h0, d[15:0]} : d;
  endfunction
  assign bus.in_ready = rst_n && r_state != WAIT_MEM;
  assign bus.busy     = r_state == WAIT_MEM;
  assign bus.wb_en    = r_wb_en;
  assign bus.wb_addr  = r_wb_addr;
  assign bus.wb_data  = r_wb_data;
  assign w_acc = bus.in_valid && bus.in_ready;
  assign w_cap = r_state == WAIT_MEM && bus.mem_rvalid;
  assign w_dst = bus.RegDst ? bus.rd : bus.rt;
  assign w_ext = ext(r_op, bus.mem_rdata);
  // register 0 writes keep their WB cycle but never raise the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_dst     <= '0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_en <= 1'b0;
      if (r_state == WAIT_MEM) begin
        if (w_cap) begin
          r_state   <= WB;
          r_wb_addr <= r_dst;
          r_wb_data <= w_ext;
          r_wb_en   <= r_dst != 5'd0;
        end
      end else if (w_acc && bus.RegWrite) begin
        if (bus.MemToReg) begin
          r_state <= WAIT_MEM;
          r_op    <= bus.opcode;
          r_dst   <= w_dst;
        end else begin
          r_state   <= WB;
          r_wb_addr <= w_dst;
          r_wb_data <= bus.alu_result;
          r_wb_en   <= w_dst != 5'd0;
        end
      end else r_state <= IDLE;
    end
  end
`ifdef WB_FWD_EN
  assign bus.fwd_valid = rst_n && (r_wb_en || (w_cap && r_dst != 5'd0));
  assign bus.fwd_addr  = w_cap ? r_dst : r_wb_addr;
  assign bus.fwd_data  = w_cap ? w_ext : r_wb_data;
`endif
endmodule

// File: tb/tb_mem_writeback_stage.sv
// tb_mem_writeback_stage: directed and random stimulus against a transaction-level reference model
module tb_mem_writeback_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  mem_wb_if bus ();
  mem_writeback_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic        m_wait, m_en;
  logic [5:0]  m_op;
  logic [4:0]  m_dst, m_addr;
  logic [31:0] m_data;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [31:0] ref_ext(input logic [5:0] op, input logic [31:0] d);
    int b, h;
    b = int'(d[7:0]);
    h = int'(d[15:0]);
    case (op)
      6'h20: return b > 127 ? b - 256 : b;
      6'h21: return h > 32767 ? h - 65536 : h;
      6'h24: return b;
      6'h25: return h;
      default: return d;
    endcase
  endfunction
  task automatic mreset();
    m_wait = 0; m_en = 0; m_op = 0; m_dst = 0; m_addr = 0; m_data = 0;
  endtask
  task automatic mstep();
    logic [4:0] d;
    m_en = 0;
    if (m_wait) begin
      if (bus.mem_rvalid) begin
        m_wait = 0; m_addr = m_dst; m_data = ref_ext(m_op, bus.mem_rdata); m_en = m_dst != 0;
      end
    end else if (bus.in_valid && bus.RegWrite) begin
      d = bus.RegDst ? bus.rd : bus.rt;
      if (bus.MemToReg) begin
        m_wait = 1; m_dst = d; m_op = bus.opcode;
      end else begin
        m_addr = d; m_data = bus.alu_result; m_en = d != 0;
      end
    end
  endtask
  task automatic chk_regs();
    chk("in_ready", 32'(bus.in_ready), 32'(rst_n && !m_wait));
    chk("busy", 32'(bus.busy), 32'(m_wait));
    chk("wb_en", 32'(bus.wb_en), 32'(m_en));
    chk("wb_addr", 32'(bus.wb_addr), 32'(m_addr));
    chk("wb_data", bus.wb_data, m_data);
  endtask
  task automatic chk_fwd();
`ifdef WB_FWD_EN
    logic cap;
    #1;
    cap = rst_n && m_wait && bus.mem_rvalid && m_dst != 0;
    chk("fwd_valid", 32'(bus.fwd_valid), 32'(m_en || cap));
    if (cap) begin
      chk("fwd_addr", 32'(bus.fwd_addr), 32'(m_dst));
      chk("fwd_data", bus.fwd_data, ref_ext(m_op, bus.mem_rdata));
    end else if (m_en) begin
      chk("fwd_addr", 32'(bus.fwd_addr), 32'(m_addr));
      chk("fwd_data", bus.fwd_data, m_data);
    end
`endif
  endtask
  task automatic drv(input logic v, input logic [5:0] op, input logic [4:0] t, input logic [4:0] d,
                     input logic dst, input logic m2r, input logic rw, input logic [31:0] alu,
                     input logic rv, input logic [31:0] rdat);
    bus.in_valid = v; bus.opcode = op; bus.rt = t; bus.rd = d; bus.RegDst = dst;
    bus.MemToReg = m2r; bus.RegWrite = rw; bus.alu_result = alu;
    bus.mem_rvalid = rv; bus.mem_rdata = rdat;
    chk_fwd();
  endtask
  task automatic tick();
    @(posedge clk);
    if (!rst_n) mreset(); else mstep();
    @(negedge clk);
    chk_regs();
  endtask
  task automatic idle(input logic rv, input logic [31:0] rdat);
    drv(0, 6'h00, 0, 0, 0, 0, 0, 32'h0, rv, rdat);
  endtask
  task automatic load_test(input logic [5:0] op, input logic [4:0] t, input logic [31:0] rdat,
                           input logic [31:0] exp);
    drv(1, op, t, 5'd9, 0, 1, 1, 32'hDEAD_BEEF, 1, rdat);
    tick();
    idle(0, rdat); tick();
    idle(0, rdat); tick();
    chk("busy_3rd", 32'(bus.busy), 32'd1);
    idle(1, rdat); tick();
    chk("ld_en", 32'(bus.wb_en), 32'(t != 0));
    chk("ld_addr", 32'(bus.wb_addr), 32'(t));
    chk("ld_data", bus.wb_data, exp);
    idle(0, 0); tick();
  endtask
  initial begin
    int ops[6] = '{32'h20, 32'h21, 32'h24, 32'h25, 32'h23, 32'h00};
    mreset();
    idle(0, 0);
    #1;
    chk_regs();
    tick();
    rst_n = 1'b1;
    #1 chk("ready_after_rst", 32'(bus.in_ready), 32'd1);
    tick();
    drv(1, 6'h00, 5'd0, 5'd5, 1, 0, 1, 32'h1234_5678, 0, 0); tick();
    chk("alu_en", 32'(bus.wb_en), 32'd1);
    chk("alu_data", bus.wb_data, 32'h1234_5678);
    idle(0, 0); tick();
    chk("alu_one_cycle", 32'(bus.wb_en), 32'd0);
    load_test(6'h20, 5'd3, 32'h0000_0080, 32'hFFFF_FF80);
    load_test(6'h24, 5'd3, 32'h0000_0080, 32'h0000_0080);
    load_test(6'h21, 5'd3, 32'h0000_8001, 32'hFFFF_8001);
    load_test(6'h25, 5'd4, 32'hFFFF_8001, 32'h0000_8001);
    load_test(6'h23, 5'd7, 32'hCAFE_F00D, 32'hCAFE_F00D);
    for (int i = 1; i <= 3; i++) begin
      drv(1, 6'h00, 5'd0, 5'(i), 1, 0, 1, 32'(i * 16), 0, 0); tick();
      chk("b2b_addr", 32'(bus.wb_addr), 32'(i));
    end
    idle(0, 0); tick();
    drv(1, 6'h00, 5'd0, 5'd0, 1, 0, 1, 32'h5555_AAAA, 0, 0); tick();
    chk("r0_en", 32'(bus.wb_en), 32'd0);
    drv(1, 6'h2B, 5'd6, 5'd6, 0, 0, 0, 32'h7777_7777, 0, 0); tick();
    chk("store_en", 32'(bus.wb_en), 32'd0);
    idle(1, 32'h1111_1111); tick();
    drv(1, 6'h23, 5'd8, 5'd0, 0, 1, 1, 32'h0, 0, 0); tick();
    idle(0, 0);
    rst_n = 1'b0;
    #1 mreset();
    chk_regs();
    tick();
    rst_n = 1'b1;
    idle(1, 32'h2222_2222); tick();
    chk("rst_load_en", 32'(bus.wb_en), 32'd0);
    for (int i = 0; i < 800; i++) begin
      drv($urandom_range(0, 3) != 0, 6'(ops[$urandom_range(0, 5)]),
          $urandom_range(0, 5) == 0 ? 5'd0 : 5'($urandom), 5'($urandom),
          1'($urandom), 1'($urandom), $urandom_range(0, 7) != 0, $urandom,
          $urandom_range(0, 2) == 0, $urandom);
      rst_n = $urandom_range(0, 150) != 0;
      if (!rst_n) begin
        #1 mreset();
        chk_regs();
      end
      tick();
      rst_n = 1'b1;
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
